// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
//
// Elastic pipeline register placed between two processor stages (IF/ID,
// ID/EX, EX/MEM, MEM/WB). A valid/ready handshake on each side takes the
// place of per-stage stall vectors.
//
// SKID=1 holds up to two entries (main + skid) so that in_ready comes
// straight from a flop. SKID=0 holds a single entry, and in_ready is derived
// combinationally from out_ready. While the stage is empty, out_data carries
// the BUBBLE (NOP) encoding. Two saturating counters record stall and bubble
// cycles for performance analysis.
//
// Parameters
//   DATA_W   payload width
//   SKID     1: two entries with registered in_ready, 0: single entry
//   BUBBLE   payload presented while out_valid=0
//   CNT_W    perf counter width
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   flush       in   kill all held entries (exception / branch redirect)
//   in_valid    in   upstream payload valid
//   in_ready    out  stage accepts this cycle
//   in_data     in   upstream payload
//   out_valid   out  output entry valid
//   out_ready   in   downstream accepts this cycle
//   out_data    out  output payload, BUBBLE when out_valid=0
//   occupancy   out  held entries: 0, 1 or 2
//   cnt_clr     in   synchronous clear of both counters
//   stall_cnt   out  cycles with out_valid=1 and out_ready=0 (saturating)
//   bubble_cnt  out  cycles with out_valid=0 (saturating)
// ---------------------------------------------------------------------------
module pipe_stage_skid #(
    parameter int                DATA_W = 32,
    parameter int                SKID   = 1,
    parameter logic [DATA_W-1:0] BUBBLE = '0,
    parameter int                CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // The state encoding matches the number of held entries, so occupancy
    // is the state register itself.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam bit               PASS    = (SKID == 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             state_q;
    logic               valid_q;
    logic               rdy_q;
    logic [DATA_W-1:0]  main_q;
    logic [DATA_W-1:0]  skid_q;
    logic [CNT_W-1:0]   stall_q;
    logic [CNT_W-1:0]   bubble_q;

    logic               accept;
    logic               drain;

    // rdy_q means "not FULL" when SKID=1. When SKID=0 it tracks "empty",
    // and the out_ready term supplies the pass-through path, which gives
    // ~out_valid | out_ready without adding a second register.
    assign in_ready   = rdy_q | (PASS & out_ready);
    assign accept     = in_valid & in_ready;
    assign drain      = valid_q & out_ready;

    assign out_valid  = valid_q;
    assign out_data   = main_q;
    assign occupancy  = state_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

    // Entry FSM. Reset and flush both collapse to EMPTY, and any
    // same-cycle accept is dropped. A same-cycle drain needs no action here
    // because downstream has already taken the payload it was shown.
    // The ONE -> FULL branch can only be taken with SKID=1: with SKID=0,
    // an accept in ONE requires out_ready, which implies a drain.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= EMPTY;
            valid_q <= 1'b0;
            rdy_q   <= 1'b1;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= in_data;
                        valid_q <= 1'b1;
                        rdy_q   <= !PASS;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_q <= in_data;
                    end else if (accept) begin
                        skid_q  <= in_data;
                        rdy_q   <= 1'b0;
                        state_q <= FULL;
                    end else if (drain) begin
                        main_q  <= BUBBLE;
                        valid_q <= 1'b0;
                        rdy_q   <= 1'b1;
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (drain) begin
                        main_q  <= skid_q;
                        rdy_q   <= 1'b1;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    valid_q <= 1'b0;
                    rdy_q   <= 1'b1;
                    main_q  <= BUBBLE;
                end
            endcase
        end
    end

    // Perf counters look at the registered out_valid and keep counting
    // through a flush. Clear takes priority over increment, and each
    // counter holds at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (valid_q && !out_ready && (stall_q != CNT_MAX)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (!valid_q && (bubble_q != CNT_MAX)) begin
                bubble_q <= bubble_q + 1'b1;
            end
        end
    end

endmodule
